// File: rtl/vip_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vip_pkg
//  Description : Shared definitions for the VIP packet arbiter. These are the
//                packet ID values carried in data[3:0] of the SOP beat, the
//                position of that ID field, and the arbiter state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package vip_pkg;

    // Packet IDs carried in the low nibble of the SOP beat
    localparam logic [3:0] PKT_ID_VIDEO = 4'h0;
    localparam logic [3:0] PKT_ID_CTRL  = 4'hF;

    // Location of the ID field inside a beat
    localparam int ID_MSB = 3;
    localparam int ID_LSB = 0;

    // Arbiter states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_e;

    // True when an SOP ID marks a control packet
    function automatic logic is_ctrl_id(input logic [3:0] id);
        return (id == PKT_ID_CTRL);
    endfunction

endpackage : vip_pkg
`default_nettype wire

// File: rtl/vip_packet_arbiter_2to1.sv
`default_nettype none
// ============================================================================
//  Module      : vip_packet_arbiter_2to1
//  Description : Packet-atomic round-robin arbiter. It shares one Avalon-ST
//                video datapath between two sources. Each packet gets one
//                grant, and granted beats pass through with zero latency.
//                Beats of different packets are never interleaved. Orphan
//                beats (valid without SOP while idle) are flushed and counted.
//  Ports       : clk, reset_n (async, active-low)
//                sink0_* / sink1_*  : Avalon-ST inputs (data/valid/ready/sop/eop)
//                source_*           : arbitrated Avalon-ST output
//                grant              : one-hot active sink, 2'b00 when idle
//                drop_count         : saturating count of flushed orphan beats
//  Options     : VIP_FRAME_LOCK_EN - after a control packet (SOP ID 4'hF) the
//                grant stays on the same source until the end of the next
//                non-control packet. The control packet and its frame
//                therefore travel together.
//  Revision    : 1.0 - initial release
// ============================================================================
module vip_packet_arbiter_2to1 #(
    parameter int DATA_W     = 30,
    parameter int DROP_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_W-1:0]     sink0_data,
    input  logic                  sink0_valid,
    output logic                  sink0_ready,
    input  logic                  sink0_sop,
    input  logic                  sink0_eop,
    input  logic [DATA_W-1:0]     sink1_data,
    input  logic                  sink1_valid,
    output logic                  sink1_ready,
    input  logic                  sink1_sop,
    input  logic                  sink1_eop,
    output logic [DATA_W-1:0]     source_data,
    output logic                  source_valid,
    input  logic                  source_ready,
    output logic                  source_sop,
    output logic                  source_eop,
    output logic [1:0]            grant,
    output logic [DROP_CNT_W-1:0] drop_count
);

    import vip_pkg::*;

    arb_state_e              state_q, state_d;
    logic                    rr_ptr_q, rr_ptr_d;     // preferred sink on a tie
    logic [DROP_CNT_W-1:0]   drop_count_q, drop_count_d;
`ifdef VIP_FRAME_LOCK_EN
    logic                    is_ctrl_q, is_ctrl_d;   // current packet is a control packet
    logic                    w_pkt_ctrl;
`endif

    logic                    w_cand0, w_cand1;
    logic                    w_flush0, w_flush1;
    logic [1:0]              w_drop_inc;
    logic [DROP_CNT_W:0]     w_drop_sum;
    logic                    w_granted;
    logic                    w_sel1;
    logic [DATA_W-1:0]       w_sel_data;
    logic                    w_sel_valid, w_sel_sop, w_sel_eop;
    logic                    w_xfer;

    // SOP requests and orphan flushes only matter while idle. The flush
    // ready is gated by reset_n so both readies read 0 during reset.
    assign w_cand0  = sink0_valid & sink0_sop;
    assign w_cand1  = sink1_valid & sink1_sop;
    assign w_flush0 = reset_n & (state_q == IDLE) & sink0_valid & ~sink0_sop;
    assign w_flush1 = reset_n & (state_q == IDLE) & sink1_valid & ~sink1_sop;

    assign w_drop_inc = {1'b0, w_flush0} + {1'b0, w_flush1};
    assign w_drop_sum = {1'b0, drop_count_q} + {{(DROP_CNT_W-1){1'b0}}, w_drop_inc};

    // Mux for the granted sink
    assign w_granted   = (state_q == GRANT0) || (state_q == GRANT1);
    assign w_sel1      = (state_q == GRANT1);
    assign w_sel_data  = w_sel1 ? sink1_data  : sink0_data;
    assign w_sel_valid = w_sel1 ? sink1_valid : sink0_valid;
    assign w_sel_sop   = w_sel1 ? sink1_sop   : sink0_sop;
    assign w_sel_eop   = w_sel1 ? sink1_eop   : sink0_eop;
    assign w_xfer      = w_granted & w_sel_valid & source_ready;

`ifdef VIP_FRAME_LOCK_EN
    // A single-beat packet carries its own ID, so classify it from the live
    // beat. Otherwise use the flag captured at this packet's SOP.
    assign w_pkt_ctrl = w_sel_sop ? is_ctrl_id(w_sel_data[ID_MSB:ID_LSB]) : is_ctrl_q;
`endif

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        drop_count_d = drop_count_q;
`ifdef VIP_FRAME_LOCK_EN
        is_ctrl_d    = is_ctrl_q;
`endif
        source_data  = '0;
        source_valid = 1'b0;
        source_sop   = 1'b0;
        source_eop   = 1'b0;
        sink0_ready  = 1'b0;
        sink1_ready  = 1'b0;

        case (state_q)
            IDLE: begin
                // Orphans are accepted and discarded. SOP holders wait.
                sink0_ready  = w_flush0;
                sink1_ready  = w_flush1;
                drop_count_d = w_drop_sum[DROP_CNT_W] ? {DROP_CNT_W{1'b1}}
                                                      : w_drop_sum[DROP_CNT_W-1:0];
                if (w_cand0 && (!w_cand1 || !rr_ptr_q)) begin
                    state_d = GRANT0;
                end else if (w_cand1) begin
                    state_d = GRANT1;
                end
            end

            GRANT0, GRANT1: begin
                source_data  = w_sel_data;
                source_valid = w_sel_valid;
                source_sop   = w_sel_sop;
                source_eop   = w_sel_eop;
                if (w_sel1) begin
                    sink1_ready = source_ready;
                end else begin
                    sink0_ready = source_ready;
                end

                if (w_xfer) begin
`ifdef VIP_FRAME_LOCK_EN
                    if (w_sel_sop) begin
                        is_ctrl_d = is_ctrl_id(w_sel_data[ID_MSB:ID_LSB]);
                    end
                    // A control packet keeps the grant for the frame after it
                    if (w_sel_eop && !w_pkt_ctrl) begin
                        state_d  = IDLE;
                        rr_ptr_d = ~w_sel1;
                    end
`else
                    if (w_sel_eop) begin
                        state_d  = IDLE;
                        rr_ptr_d = ~w_sel1;
                    end
`endif
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= 1'b0;
            drop_count_q <= '0;
`ifdef VIP_FRAME_LOCK_EN
            is_ctrl_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            drop_count_q <= drop_count_d;
`ifdef VIP_FRAME_LOCK_EN
            is_ctrl_q    <= is_ctrl_d;
`endif
        end
    end

    // grant is a decode of the state register, so it changes only on clock edges
    assign grant      = {(state_q == GRANT1), (state_q == GRANT0)};
    assign drop_count = drop_count_q;

endmodule : vip_packet_arbiter_2to1
`default_nettype wire
